// File: rtl/sensor_alarm.sv
// Debounces a raw sensor error flag into a latched, ack-cleared alarm with snapshot and event count.
// Optional escalation output/timeout is compiled in when ALARM_ESCALATE_EN is defined.
module sensor_alarm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8,
  parameter int ESC_CYCLES      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 error,
  input  logic [3:0]           sensors,
  input  logic                 ack,
  output logic                 alarm,
  output logic [3:0]           alarm_code,
`ifdef ALARM_ESCALATE_EN
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 escalate
`else
  output logic [CNT_WIDTH-1:0] error_count
`endif
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] QUALIFY    = 2'd1;
  localparam logic [1:0] ALARM      = 2'd2;
  localparam logic [1:0] WAIT_CLEAR = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           state_q, state_d;
  logic [7:0]           deb_q, deb_d;
  logic                 alarm_q, alarm_d;
  logic [3:0]           code_q, code_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 qualify;

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    qualify = 1'b0;
    case (state_q)
      IDLE: begin
        if (error) begin
          if (DEBOUNCE_CYCLES == 1) begin
            qualify = 1'b1;
          end else begin
            state_d = QUALIFY;
            deb_d   = 8'd1;
          end
        end
      end
      QUALIFY: begin
        if (!error) begin
          state_d = IDLE;
          deb_d   = 8'd0;
        end else if ({1'b0, deb_q} + 9'd1 >= 9'(DEBOUNCE_CYCLES)) begin
          qualify = 1'b1;
        end else begin
          deb_d = deb_q + 8'd1;
        end
      end
      ALARM: begin
        // A fault still present at ack parks in WAIT_CLEAR so it is counted once.
        if (ack) state_d = error ? WAIT_CLEAR : IDLE;
      end
      WAIT_CLEAR: begin
        if (!error) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (qualify) begin
      state_d = ALARM;
      deb_d   = 8'd0;
      code_d  = sensors;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end
    alarm_d = (state_d == ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      deb_q   <= 8'd0;
      alarm_q <= 1'b0;
      code_q  <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      alarm_q <= alarm_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_code  = code_q;
  assign error_count = cnt_q;

`ifdef ALARM_ESCALATE_EN
  localparam int ESC_W = $clog2(ESC_CYCLES + 1) + 1;
  localparam logic [ESC_W-1:0] ESC_LIMIT = ESC_W'(ESC_CYCLES);

  logic [ESC_W-1:0] esc_cnt_q, esc_cnt_d;
  logic             escalate_q, escalate_d;

  // Timer runs only while sitting in ALARM unacknowledged; any exit clears it.
  always_comb begin
    esc_cnt_d = esc_cnt_q;
    if (state_d != ALARM) begin
      esc_cnt_d = '0;
    end else if (state_q == ALARM && !ack && esc_cnt_q != ESC_LIMIT) begin
      esc_cnt_d = esc_cnt_q + ESC_W'(1);
    end
    escalate_d = (state_d == ALARM) && (escalate_q || esc_cnt_d == ESC_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      esc_cnt_q  <= '0;
      escalate_q <= 1'b0;
    end else begin
      esc_cnt_q  <= esc_cnt_d;
      escalate_q <= escalate_d;
    end
  end

  assign escalate = escalate_q;
`endif

endmodule
